// File: rtl/line_fill_memory_if.sv
`default_nettype none
// ============================================================================
//  Module      : line_fill_memory_if
//  Description : Miss-side bus between the cache controller and the line-fill
//                backing store: level requests, line address, write-back line,
//                and the fill line / completion pulses coming back.
//  Revision    : 1.0 - initial release
// ============================================================================
interface line_fill_memory_if #(
  parameter int LINE_BITS = 512
);
  logic                 ask_for_data;
  logic                 wb_req;
  logic [31:0]          req_addr;
  logic [LINE_BITS-1:0] wb_data;
  logic [LINE_BITS-1:0] data_to_write;
  logic                 fill_valid;
  logic                 wb_done;
  logic                 busy;

  // Cache controller side: issues requests, consumes fills and completions.
  modport master (
    output ask_for_data, wb_req, req_addr, wb_data,
    input  data_to_write, fill_valid, wb_done, busy
  );

  // Backing store side: answers requests.
  modport slave (
    input  ask_for_data, wb_req, req_addr, wb_data,
    output data_to_write, fill_valid, wb_done, busy
  );
endinterface : line_fill_memory_if
`default_nettype wire

// File: rtl/line_fill_memory.sv
`default_nettype none
// ============================================================================
//  Module      : line_fill_memory
//  Description : Fixed-latency backing store for the cache miss interface.
//                Answers line-fill requests with a full line and commits
//                dirty-line write-backs. One transaction in flight at a time;
//                a simultaneous write-back is served before the refill.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_fill_memory #(
  parameter int LINE_BITS     = 512,
  parameter int OFFSET_BITS   = 6,
  parameter int DEPTH_LINES   = 1024,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 2
) (
  input  wire logic         clk,
  input  wire logic         rst,   // asynchronous, active-low
  line_fill_memory_if.slave bus
);

  localparam int IDX_W   = $clog2(DEPTH_LINES);
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] WR_WAIT = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);

  // Line storage; contents survive reset on purpose.
  logic [LINE_BITS-1:0] mem [DEPTH_LINES];

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [LINE_BITS-1:0] wdata_q, wdata_d;
  logic [LINE_BITS-1:0] data_to_write_q, data_to_write_d;
  logic                 fill_valid_q, fill_valid_d;
  logic                 wb_done_q, wb_done_d;
  logic                 mem_we;
  logic                 busy;
  logic                 cnt_zero;
  logic [IDX_W-1:0]     req_idx;

  // Offset and aliasing bits of the address play no role in line selection.
  logic                 unused_addr_bits;

  assign req_idx          = bus.req_addr[OFFSET_BITS +: IDX_W];
  assign unused_addr_bits = ^{bus.req_addr[31:OFFSET_BITS+IDX_W],
                              bus.req_addr[OFFSET_BITS-1:0]};
  assign cnt_zero         = (cnt_q == '0);

  // State register plus captured request and registered responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      idx_q           <= '0;
      wdata_q         <= '0;
      data_to_write_q <= '0;
      fill_valid_q    <= 1'b0;
      wb_done_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      idx_q           <= idx_d;
      wdata_q         <= wdata_d;
      data_to_write_q <= data_to_write_d;
      fill_valid_q    <= fill_valid_d;
      wb_done_q       <= wb_done_d;
    end
  end

  // Next-state: accept in IDLE (write-back first), count down, one RESP cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (bus.wb_req) begin
          idx_d   = req_idx;
          wdata_d = bus.wb_data;
          cnt_d   = WR_LOAD;
          state_d = WR_WAIT;
        end else if (bus.ask_for_data) begin
          idx_d   = req_idx;
          cnt_d   = RD_LOAD;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (cnt_zero) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: pulses and fill data are launched on the last wait cycle.
  always_comb begin
    fill_valid_d    = 1'b0;
    wb_done_d       = 1'b0;
    data_to_write_d = data_to_write_q;
    mem_we          = 1'b0;
    busy            = (state_q != IDLE);
    if (state_q == RD_WAIT && cnt_zero) begin
      fill_valid_d    = 1'b1;
      data_to_write_d = mem[idx_q];
    end
    if (state_q == WR_WAIT && cnt_zero) begin
      wb_done_d = 1'b1;
      mem_we    = 1'b1;
    end
  end

  // Memory write; reset forces IDLE asynchronously, so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign bus.data_to_write = data_to_write_q;
  assign bus.fill_valid    = fill_valid_q;
  assign bus.wb_done       = wb_done_q;
  assign bus.busy          = busy;

endmodule : line_fill_memory
`default_nettype wire

// File: tb/tb_line_fill_memory.sv
`default_nettype none
// ============================================================================
//  Module      : tb_line_fill_memory
//  Description : Self-checking bench for line_fill_memory. A line-indexed
//                associative array models the store; latencies and pulse
//                spacing are derived from the parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_line_fill_memory;

  localparam int LINE_BITS     = 512;
  localparam int OFFSET_BITS   = 6;
  localparam int DEPTH_LINES   = 1024;
  localparam int READ_LATENCY  = 4;
  localparam int WRITE_LATENCY = 2;
  localparam int BOUND         = 40;

  typedef logic [LINE_BITS-1:0] line_t;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  line_fill_memory_if #(.LINE_BITS(LINE_BITS)) bus ();

  line_fill_memory #(
    .LINE_BITS    (LINE_BITS),
    .OFFSET_BITS  (OFFSET_BITS),
    .DEPTH_LINES  (DEPTH_LINES),
    .READ_LATENCY (READ_LATENCY),
    .WRITE_LATENCY(WRITE_LATENCY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  line_t model_mem [int];
  int    n_checks = 0;
  int    n_fail   = 0;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input line_t got, input line_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int line_index(input logic [31:0] addr);
    return int'((addr >> OFFSET_BITS) % DEPTH_LINES);
  endfunction

  function automatic line_t rand_line();
    line_t l;
    for (int i = 0; i < LINE_BITS / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Count negedges until the chosen pulse appears; also tally busy cycles
  // and whether the other pulse showed up meanwhile.
  task automatic wait_pulse(input bit want_fill, output int lat, output int busy_cnt,
                            output int other_seen);
    lat = 0; busy_cnt = 0; other_seen = 0;
    while (lat < BOUND) begin
      if (bus.busy) busy_cnt++;
      if (want_fill ? bus.wb_done : bus.fill_valid) other_seen++;
      if (want_fill ? bus.fill_valid : bus.wb_done) break;
      @(negedge clk);
      lat++;
    end
  endtask

  // Called at a negedge with the FSM idle.
  task automatic do_write(input string tag, input logic [31:0] addr, input line_t data);
    int lat, bc, oth;
    bus.wb_req   = 1'b1;
    bus.req_addr = addr;
    bus.wb_data  = data;
    @(negedge clk);
    bus.wb_req   = 1'b0;
    bus.req_addr = $urandom;
    bus.wb_data  = rand_line();
    wait_pulse(1'b0, lat, bc, oth);
    check({tag, "_wr_lat"}, line_t'(lat), line_t'(WRITE_LATENCY));
    check({tag, "_wr_nofill"}, line_t'(oth), '0);
    model_mem[line_index(addr)] = data;
    @(negedge clk);
    check({tag, "_wr_pulse1"}, line_t'(bus.wb_done), '0);
    check({tag, "_wr_idle"}, line_t'(bus.busy), '0);
  endtask

  // Called at a negedge with the FSM idle.
  task automatic do_read(input string tag, input logic [31:0] addr);
    int    lat, bc, oth, idx;
    line_t got;
    idx = line_index(addr);
    bus.ask_for_data = 1'b1;
    bus.req_addr     = addr;
    @(negedge clk);
    bus.ask_for_data = 1'b0;
    bus.req_addr     = $urandom;
    wait_pulse(1'b1, lat, bc, oth);
    got = bus.data_to_write;
    check({tag, "_rd_lat"}, line_t'(lat), line_t'(READ_LATENCY));
    check({tag, "_rd_busy"}, line_t'(bc), line_t'(READ_LATENCY + 1));
    check({tag, "_rd_nowb"}, line_t'(oth), '0);
    if (model_mem.exists(idx)) check({tag, "_rd_data"}, got, model_mem[idx]);
    @(negedge clk);
    check({tag, "_rd_pulse1"}, line_t'(bus.fill_valid), '0);
    check({tag, "_rd_idle"}, line_t'(bus.busy), '0);
    check({tag, "_rd_hold"}, bus.data_to_write, got);
  endtask

  initial begin : main
    line_t pat_a, pat_b, last_fill;
    int    lat, bc, oth, cnt, prev_pulse, pulses, ctr;
    int    pulse_at[$];

    bus.ask_for_data = 1'b0;
    bus.wb_req       = 1'b0;
    bus.req_addr     = '0;
    bus.wb_data      = '0;
    rst = 1'b1;
    #1 rst = 1'b0;

    // Reset held with a pending fill request.
    bus.ask_for_data = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_fill_valid", line_t'(bus.fill_valid), '0);
    check("rst_wb_done", line_t'(bus.wb_done), '0);
    check("rst_busy", line_t'(bus.busy), '0);
    check("rst_data", bus.data_to_write, '0);
    rst = 1'b1;
    do_read("rst_rel", 32'h0000_0000);

    // Write then read the same line.
    pat_a = {16{32'hDEADBEEF}};
    do_write("wr_rd", 32'h0000_0040, pat_a);
    do_read("wr_rd", 32'h0000_0040);

    // Simultaneous requests: write-back first, fill afterwards sees new data.
    bus.wb_req       = 1'b1;
    bus.ask_for_data = 1'b1;
    bus.req_addr     = 32'h0000_0140;
    bus.wb_data      = line_t'(1);
    @(negedge clk);
    bus.wb_req = 1'b0;
    wait_pulse(1'b0, lat, bc, oth);
    check("simul_wb_lat", line_t'(lat), line_t'(WRITE_LATENCY));
    check("simul_wb_nofill", line_t'(oth), '0);
    model_mem[5] = line_t'(1);
    @(negedge clk);   // RESP -> IDLE at this edge; read accepted at the next
    @(negedge clk);
    bus.ask_for_data = 1'b0;
    bus.req_addr     = $urandom;
    wait_pulse(1'b1, lat, bc, oth);
    check("simul_rd_lat", line_t'(lat), line_t'(READ_LATENCY));
    check("simul_rd_data", bus.data_to_write, line_t'(1));
    @(negedge clk);

    // Aliasing and ignored offset bits.
    pat_b = rand_line();
    do_write("alias", 32'h0000_0080, pat_b);
    do_read("alias", 32'h0001_00BF);

    // Reset in the middle of a write-back: memory keeps the old line.
    bus.wb_req   = 1'b1;
    bus.req_addr = 32'h0000_0040;
    bus.wb_data  = rand_line();
    @(negedge clk);
    bus.wb_req = 1'b0;
    rst        = 1'b0;
    @(negedge clk);
    check("midrst_busy", line_t'(bus.busy), '0);
    check("midrst_wb_done", line_t'(bus.wb_done), '0);
    check("midrst_data", bus.data_to_write, '0);
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.wb_done) cnt++;
    end
    check("midrst_no_pulse", line_t'(cnt), '0);
    do_read("midrst", 32'h0000_0040);

    // Held fill request: periodic single-cycle pulses, stable data between.
    bus.ask_for_data = 1'b1;
    bus.req_addr     = 32'h0000_0080;
    prev_pulse = 0;
    pulses     = 0;
    last_fill  = bus.data_to_write;
    for (int c = 0; c < BOUND; c++) begin
      @(negedge clk);
      if (bus.fill_valid) begin
        if (prev_pulse != 0) check("held_consec", 1, 0);
        check("held_data", bus.data_to_write, model_mem[2]);
        last_fill = bus.data_to_write;
        pulse_at.push_back(c);
        pulses++;
        prev_pulse = 1;
      end else begin
        if (pulses > 0) check("held_stable", bus.data_to_write, last_fill);
        prev_pulse = 0;
      end
    end
    bus.ask_for_data = 1'b0;
    check("held_count_min", line_t'(pulses >= 5), line_t'(1));
    for (int i = 1; i < pulse_at.size(); i++)
      check("held_period", line_t'(pulse_at[i] - pulse_at[i-1]), line_t'(READ_LATENCY + 2));
    ctr = 0;
    while (bus.busy && ctr < BOUND) begin
      @(negedge clk);
      ctr++;
    end
    check("held_drain", line_t'(bus.busy), '0);

    // Randomized traffic over a small set of lines with random alias/offset bits.
    for (int i = 0; i < 8; i++)
      do_write("rnd_init", (32'(i) << OFFSET_BITS) | 32'(1024 * 64 * $urandom_range(0, 15)), rand_line());
    for (int n = 0; n < 30; n++) begin
      logic [31:0] a;
      a = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 7)) << OFFSET_BITS)
          | 32'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 0) do_write("rnd", a, rand_line());
      else                           do_read("rnd", a);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_line_fill_memory
`default_nettype wire

// File: doc/line_fill_memory.md
# line_fill_memory

Backing-store responder on the far side of the cache's miss interface. It answers the cache's `ask_for_data` line-fill requests with a full 512-bit line on `data_to_write`, and it absorbs dirty-line write-backs. Each operation has a fixed, parameterised latency. It sits between the cache controller and simulation/top-level memory, and is the single source of refill data for the cache.

## Interface
Parameters:
- `LINE_BITS`, 512: line width in bits; matches the cache block (64 bytes).
- `OFFSET_BITS`, 6: byte-offset bits ignored in `req_addr`.
- `DEPTH_LINES`, 1024: stored lines; must be a power of 2; index = `req_addr[OFFSET_BITS +: $clog2(DEPTH_LINES)]`; upper address bits are ignored (aliasing is allowed).
- `READ_LATENCY`, 4: accept-to-`fill_valid` delay in clocks; must be ≥1.
- `WRITE_LATENCY`, 2: accept-to-`wb_done` delay in clocks; must be ≥1.

Ports:
- `clk` in 1: single clock; rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `ask_for_data` in 1: level line-fill request from the cache.
- `wb_req` in 1: level write-back request.
- `req_addr` in 32: line address for either request.
- `wb_data` in LINE_BITS: write-back line.
- `data_to_write` out LINE_BITS: fill line returned to the cache.
- `fill_valid` out 1: one-cycle pulse; `data_to_write` is valid.
- `wb_done` out 1: one-cycle pulse; write-back committed.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, RD_WAIT, WR_WAIT, RESP.
- IDLE: requests are sampled only in this state.
  - If `wb_req`=1: capture `req_addr` index and `wb_data`, load `cnt`←WRITE_LATENCY-1, go to WR_WAIT.
  - Else if `ask_for_data`=1: capture the index, load `cnt`←READ_LATENCY-1, go to RD_WAIT.
- Simultaneous requests: the write-back wins, so the victim is committed before the refill. The read stays pending and is accepted in the next IDLE cycle.
- RD_WAIT: if `cnt`==0, register `data_to_write`←mem[idx], set `fill_valid`, go to RESP; otherwise decrement `cnt`.
- WR_WAIT: if `cnt`==0, write mem[idx]←captured data, set `wb_done`, go to RESP; otherwise decrement `cnt`.
- RESP: lasts exactly one cycle. Pulses clear and the FSM returns to IDLE unconditionally. Requests are not sampled in RESP, so a requester that drops its level on the pulse edge is never re-accepted.
- Request inputs and `req_addr` changing after acceptance have no effect; the captured values are used.
- A fill that follows a write-back to the same index returns the new data.
- `data_to_write` holds its last fill value until the next fill; it is not cleared after RESP.

## Timing
- Reset (async assert, while `rst`=0): state IDLE, `cnt`=0, `fill_valid`=0, `wb_done`=0, `busy`=0, `data_to_write`=0. Memory array contents are not reset.
- Reset mid-operation:
  - The transaction is aborted.
  - A write in WR_WAIT that has not reached `cnt`==0 does not modify memory.
  - No pulse is issued after reset is released.
- Read latency: request sampled at edge E0 → `fill_valid` and data are high from edge E0+READ_LATENCY for exactly one cycle.
- Write latency: sampled at E0 → memory updated and `wb_done` high from E0+WRITE_LATENCY for one cycle.
- `busy` rises at E0 and falls one cycle after the pulse (RESP→IDLE).
- Back-to-back throughput: one transaction per LATENCY+2 cycles.

## Test plan
- Reset values: hold `rst`=0 with `ask_for_data`=1 → all outputs 0 and `busy`=0. Release reset → read accepted at the first edge; `fill_valid` 4 edges later.
- Write then read: write-back `req_addr`=0x0000_0040, `wb_data`={16{32'hDEADBEEF}} → `wb_done` pulse at E0+2. Then fill the same address → `fill_valid` at E0'+4 with the same 512-bit pattern, `busy` high for 5 cycles.
- Simultaneous requests: `wb_req`=`ask_for_data`=1, same index 5, `wb_data`=512'h1 → `wb_done` first; the fill is accepted at the IDLE after RESP and returns 512'h1.
- Aliasing and offset: write 0x0000_0080 = A. Read 0x0001_00BF → returns A (index 2, upper and offset bits ignored).
- Reset mid-write: write 0x40 = B over old value A, pulse `rst` low during WR_WAIT with `cnt`=1. Then read 0x40 → returns A, and no `wb_done` is ever seen.
- Held request: keep `ask_for_data`=1 continuously → `fill_valid` pulses every 6 cycles, never two consecutive cycles, and `data_to_write` is stable between pulses.
